// File: rtl/word_assembler.sv
// Byte-serial to 32-bit word assembler feeding the load register stage.
// Collects four bytes over valid/ready, then presents the word with a one-cycle load pulse.
module word_assembler #(
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             abort,
  output logic [31:0]      word_out,
  output logic             load,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic {FILL = 1'b0, EMIT = 1'b1} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [WORD_W-1:0]  acc;
  logic [WORD_W-1:0]  acc_next;
  logic [IDX_W-1:0]   lane;

  // Lane order flips for big-endian assembly; lane n sits at bits [8n+7:8n].
  always_comb begin
    lane     = MSB_FIRST ? ~idx : idx;
    acc_next = acc;
    acc_next[{lane, 3'b000} +: 8] = byte_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      idx        <= '0;
      acc        <= '0;
      word_out   <= '0;
      load       <= 1'b0;
      word_count <= '0;
      byte_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      load <= 1'b0;
      case (state)
        FILL: begin
          // Abort wins over a byte offered in the same cycle.
          if (abort) begin
            idx  <= '0;
            busy <= 1'b0;
          end else if (byte_valid) begin
            acc <= acc_next;
            idx <= idx + IDX_W'(1);
            if (idx == IDX_W'(3)) begin
              word_out   <= acc_next;
              state      <= EMIT;
              load       <= 1'b1;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
            end else begin
              busy <= 1'b1;
            end
          end
        end
        EMIT: begin
          state      <= FILL;
          idx        <= '0;
          word_count <= word_count + CNT_W'(1);
          byte_ready <= 1'b1;
          busy       <= 1'b0;
        end
        default: begin
          state      <= FILL;
          idx        <= '0;
          byte_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_assembler.sv
// Bench for word_assembler: three configurations share one stimulus stream and one
// byte-level reference model, plus literal checks for the directed scenarios.
module tb_word_assembler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        abort = 1'b0;

  logic        rdy0, rdy1, rdy2;
  logic [31:0] w0, w1, w2;
  logic        ld0, ld1, ld2;
  logic        bz0, bz1, bz2;
  logic [15:0] c0, c1;
  logic [1:0]  c2;
  logic [31:0] out1;

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  word_assembler #(.MSB_FIRST(1'b0), .CNT_W(16)) dut_le (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(rdy0), .abort(abort), .word_out(w0), .load(ld0), .busy(bz0), .word_count(c0));
  word_assembler #(.MSB_FIRST(1'b1), .CNT_W(16)) dut_be (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(rdy1), .abort(abort), .word_out(w1), .load(ld1), .busy(bz1), .word_count(c1));
  word_assembler #(.MSB_FIRST(1'b0), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(rdy2), .abort(abort), .word_out(w2), .load(ld2), .busy(bz2), .word_count(c2));

  // Downstream load register fed by the big-endian instance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) out1 <= '0;
    else if (ld1) out1 <= w1;
  end

  // Reference model: bytes of the current word, the last finished word, and an emit flag.
  logic [7:0] cur [4];
  logic [7:0] last [4];
  int  n = 0;
  bit  pend = 1'b0;
  int  cnt = 0;
  logic [31:0] exp_out1 = '0;

  function automatic logic [31:0] packw(bit msb);
    if (msb) return {last[0], last[1], last[2], last[3]};
    return {last[3], last[2], last[1], last[0]};
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) last[i] = 8'h00;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; pend = 1'b0; cnt = 0; exp_out1 = '0;
      for (int i = 0; i < 4; i++) last[i] = 8'h00;
    end else if (pend) begin
      pend = 1'b0;
      cnt = cnt + 1;
      exp_out1 = packw(1'b1);
    end else if (abort) begin
      n = 0;
    end else if (byte_valid) begin
      cur[n] = byte_in;
      n = n + 1;
      if (n == 4) begin
        for (int i = 0; i < 4; i++) last[i] = cur[i];
        pend = 1'b1;
        n = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of all three instances against the model.
  always @(posedge clk) begin
    #1;
    if (checking) begin
      chk("load_le", 32'(ld0), 32'(pend));
      chk("load_be", 32'(ld1), 32'(pend));
      chk("load_c2", 32'(ld2), 32'(pend));
      chk("ready", {29'd0, rdy0, rdy1, rdy2}, {29'd0, !pend, !pend, !pend});
      chk("busy", {29'd0, bz0, bz1, bz2}, {29'd0, {3{!pend && n != 0}}});
      chk("word_le", w0, packw(1'b0));
      chk("word_be", w1, packw(1'b1));
      chk("word_c2", w2, packw(1'b0));
      chk("cnt16", 32'(c0), 32'(cnt % 65536));
      chk("cnt16_be", 32'(c1), 32'(cnt % 65536));
      chk("cnt2", 32'(c2), 32'(cnt % 4));
      chk("out1", out1, exp_out1);
    end
  end

  // Offer a byte; valid stays high until the transfer edge, retrying through the bubble.
  task automatic send(input logic [7:0] b);
    int guard;
    @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    guard = 0;
    while (!rdy0 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8) chk("ready_timeout", 32'(rdy0), 32'd1);
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (k - 1) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_word", w0, 32'h0);
    chk("rst_load", 32'(ld0), 32'd0);
    chk("rst_ready", 32'(rdy0), 32'd1);
    chk("rst_busy", 32'(bz0), 32'd0);
    rst_n = 1'b1;
    checking = 1'b1;

    // Basic little/big-endian assembly
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    @(posedge clk); #1;
    chk("lit_le_word", w0, 32'h44332211);
    chk("lit_le_load", 32'(ld0), 32'd1);
    chk("lit_be_word", w1, 32'h11223344);
    idle(2);
    chk("lit_cnt1", 32'(c0), 32'd1);

    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    @(posedge clk); #1;
    chk("lit_deadbeef", w1, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("lit_out1", out1, 32'hDEADBEEF);
    chk("lit_load_once", 32'(ld1), 32'd0);
    idle(1);

    // Continuous valid through the bubble
    for (int i = 1; i <= 8; i++) send(8'(i));
    @(posedge clk); #1;
    chk("lit_stream2", w0, 32'h08070605);
    idle(2);

    // Abort discards partial word and the byte offered with it
    send(8'hAA); send(8'hBB);
    @(negedge clk);
    abort = 1'b1; byte_valid = 1'b1; byte_in = 8'hCC;
    @(negedge clk);
    abort = 1'b0; byte_valid = 1'b0;
    chk("lit_abort_hold", w0, 32'h08070605);
    for (int i = 1; i <= 4; i++) send(8'(i));
    @(posedge clk); #1;
    chk("lit_abort_word", w0, 32'h04030201);
    idle(2);
    chk("lit_wrap_cnt", 32'(c2), 32'd1);

    // Asynchronous reset between edges, mid-word
    send(8'h10); send(8'h20); send(8'h30);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("lit_arst_word", w0, 32'h0);
    chk("lit_arst_load", 32'(ld0), 32'd0);
    chk("lit_arst_cnt", 32'(c0), 32'd0);
    chk("lit_arst_busy", 32'(bz0), 32'd0);
    byte_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
    @(posedge clk); #1;
    chk("lit_post_rst", w0, 32'hD4C3B2A1);
    idle(2);

    // Randomized traffic
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      byte_valid = ($urandom_range(0, 3) != 0);
      byte_in = 8'($urandom);
      abort = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    byte_valid = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_assembler.md
# word_assembler

Byte-serial to 32-bit word assembler that sits directly upstream of the 32-bit load register stage (`main`). It collects bytes over a valid/ready handshake and presents a complete word on `word_out`, which drives the register's `in1`. It pulses `load` for exactly one cycle when a new word is ready, so the downstream register captures each word once.

## Interface
- `MSB_FIRST`, 0, byte order: 0 places the first byte in [7:0], 1 places it in [31:24]
- `CNT_W`, 16, width of the emitted-word counter
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset; one clock, asynchronous active-low reset
- `byte_in`  in  8  incoming byte
- `byte_valid`  in  1  `byte_in` valid this cycle
- `byte_ready`  out  1  assembler can accept a byte this cycle
- `abort`  in  1  synchronous discard of the partially assembled word
- `word_out`  out  32  last completed word; connects to downstream `in1`
- `load`  out  1  one-cycle pulse, `word_out` is new; connects to downstream `load`
- `busy`  out  1  partial word held (byte count is 1-3)
- `word_count`  out  CNT_W  number of words emitted, modulo 2^CNT_W

## Operation
- A byte transfer occurs on a rising edge when `byte_valid && byte_ready`.
- Internal state: shift register `acc[31:0]`, byte index `idx[1:0]`, FSM with states FILL and EMIT.
- **FILL**
  - `byte_ready` = 1.
  - Each transfer writes `byte_in` into `acc` lane `idx`. With MSB_FIRST=0, lane n is bits [8n+7:8n]. With MSB_FIRST=1, lane n is bits [31-8n:24-8n].
  - Each transfer increments `idx`.
  - On the transfer with `idx`==3, the next state is EMIT.
- **EMIT** (lasts exactly one cycle)
  - `byte_ready` = 0 and `load` = 1.
  - `word_out` already holds the completed word.
  - `word_count` increments on leaving EMIT, wrapping from all-ones to 0.
  - Next state is FILL with `idx` = 0.
- `word_out` is registered and updates only on the FILL->EMIT edge. Between emits it holds its value; partial bytes never appear on it.
- Lanes not yet written in the current word are don't-care internally. They are never exposed.
- **`abort`**
  - In FILL: `idx` <= 0, and any byte offered in the same cycle is discarded, because abort has priority. `byte_ready` stays 1.
  - In EMIT: ignored. The emit completes and is counted.
- `busy` = (state==FILL && `idx`!=0).
- Reset (asynchronous, any time, including mid-word or during EMIT):
  - state FILL, `idx` 0, `acc` 0, `word_out` 0, `load` 0, `word_count` 0.
  - Outputs after reset: `byte_ready` = 1, `busy` = 0.
  - A partial word is lost. A pending EMIT is cancelled: no `load` pulse, no count.

## Timing
- Latency: 4th byte accepted at edge N -> `word_out` valid and `load` = 1 during cycle N..N+1 -> downstream register captures at edge N+1.
- Maximum throughput is 4 bytes per 5 cycles, because of the forced 1-cycle bubble at EMIT.
- `load` is never high on two consecutive cycles.
- `byte_ready` depends only on state, never combinationally on `byte_valid`.
- The upstream source may hold `byte_valid` high through the bubble. The byte is accepted on the first FILL cycle.
- All outputs are registered or decoded from registered state only.

## Test plan
- **Basic little-endian** (MSB_FIRST=0): send 0x11,0x22,0x33,0x44 back-to-back.
  - `word_out` = 0x44332211 with `load` = 1 for one cycle, exactly 1 cycle after the 4th transfer.
  - `word_count` = 1.
- **Big-endian** (MSB_FIRST=1): send 0xDE,0xAD,0xBE,0xEF.
  - `word_out` = 0xDEADBEEF.
  - Downstream register `out1` = 0xDEADBEEF one cycle after the `load` pulse.
- **Continuous valid**: hold `byte_valid` high and stream 8 bytes 0x01..0x08.
  - `byte_ready` drops for exactly one cycle after byte 4; 0x05 is not lost.
  - Two `load` pulses, 5 cycles apart: 0x04030201 then 0x08070605.
- **Abort**: send 0xAA,0xBB, then assert `abort` together with `byte_valid` (0xCC), then send 0x01..0x04.
  - 0xCC is dropped.
  - Single load of 0x04030201. `word_out` held its old value throughout the abort.
- **Reset mid-operation**: send 3 bytes, then pulse `rst_n` low asynchronously between edges.
  - All outputs return to reset values immediately: `word_out` = 0, `load` = 0, `word_count` = 0, `busy` = 0.
  - The next 4 bytes form a clean word.
- **Counter wrap** (CNT_W=2): emit 5 words.
  - `word_count` sequence 1,2,3,0,1.
  - Every emit has exactly one `load` pulse.
